fwd_scoreboard_id: RTL

FWD_SCOREBOARD_ID -- requirements
Module: fwd_scoreboard_id

---
 rtl/fwd_scoreboard_id.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard_id.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : fwd_scoreboard_id                                        |
// | Desc   : ID-stage RAW/WAW scoreboard with forward-select output   |
// |          and a single outstanding variable-latency accelerator op |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module fwd_scoreboard_id #(
    parameter int NUM_RS           = 2,
    parameter int DEPTH            = 3,
    parameter int FWD_MIN_STAGE    = 2,
    parameter int LOAD_READY_STAGE = 3,
    localparam int SEL_W           = $clog2(DEPTH + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_reg_write,
    input  logic                    issue_load,
    input  logic                    issue_long,
    input  logic                    acc_done,
    input  logic [NUM_RS-1:0]       need_rs,
    input  logic [NUM_RS*5-1:0]     rs_id,
    output logic [NUM_RS*SEL_W-1:0] fwd_sel,
    output logic                    stall_id,
    output logic                    acc_busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [DEPTH:1]  r_valid;
    logic [DEPTH:1]  r_load;
    logic [4:0]      r_rd [1:DEPTH];
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [4:0]      r_acc_rd;
    logic            w_acc_load;
    logic [DEPTH:1]  w_ready;
    logic [NUM_RS-1:0] w_raw_vec;
    logic            w_busy;
    logic            w_stall;
    logic            w_accept;
    logic            w_enter;

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            w_ready[k] = r_valid[k] & (r_load[k] ? (k >= LOAD_READY_STAGE)
                                                 : (k >= FWD_MIN_STAGE));
        end
    end

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        logic [4:0]       w_rs;
        logic [SEL_W-1:0] w_sel;
        logic             w_raw;
        logic             w_hit;

        assign w_rs = rs_id[5*p +: 5];

        // Scan oldest to youngest so the youngest matching producer wins.
        always_comb begin
            w_sel = '0;
            w_raw = 1'b0;
            w_hit = 1'b0;
            if (need_rs[p] && (w_rs != 5'd0)) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (r_valid[k] && (r_rd[k] == w_rs)) begin
                        w_hit = 1'b1;
                        w_sel = w_ready[k] ? SEL_W'(k) : '0;
                        w_raw = ~w_ready[k];
                    end
                end
                if (!w_hit) begin
                    if ((r_state == c_st_done) && (r_acc_rd == w_rs)) begin
                        w_sel = SEL_W'(DEPTH + 1);
                    end else if ((r_state == c_st_busy) && (r_acc_rd == w_rs)) begin
                        w_raw = 1'b1;
                    end
                end
            end
        end

        assign fwd_sel[p*SEL_W +: SEL_W] = rst ? '0 : w_sel;
        assign w_raw_vec[p]              = w_raw;
    end

    assign w_busy   = (r_state == c_st_busy);
    assign w_stall  = (|w_raw_vec)
                    | (issue_valid & issue_long & w_busy)
                    | (issue_valid & issue_reg_write & w_busy & (issue_rd == r_acc_rd));
    assign stall_id = w_stall & ~rst;
    assign acc_busy = w_busy & ~rst;
    assign w_accept = issue_valid & ~w_stall;
    assign w_enter  = w_accept & issue_reg_write & ~issue_long & (issue_rd != 5'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_load  = 1'b0;
        case (r_state)
            c_st_busy: begin
                if (acc_done) begin
                    w_state_nxt = c_st_done;
                end
            end
            default: begin
                if (w_accept && issue_long) begin
                    w_state_nxt = c_st_busy;
                    w_acc_load  = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_load   <= '0;
            r_state  <= c_st_idle;
            r_acc_rd <= 5'd0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= 5'd0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[1] <= w_enter;
            r_load[1]  <= issue_load;
            r_rd[1]    <= issue_rd;
            r_state    <= w_state_nxt;
            if (w_acc_load) begin
                r_acc_rd <= issue_rd;
            end
        end
    end

endmodule
`default_nettype wire
